// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Holds the PC, fetches over a
//               req/ready memory port, presents one EXEC cycle per instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        Jump,
    input  logic        JumpSel,
    input  logic        Branch,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign pc_plus4  = pc + 32'd4;

    // Jump outranks Branch; a taken BNE is relative to the delay-free pc+4.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump && JumpSel) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (Branch && !alu_zero) begin
            next_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
            fetch_fault <= 1'b0;
            wait_cnt    <= 8'h0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        wait_cnt    <= 8'h0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        imem_req    <= 1'b0;
                        fetch_fault <= 1'b1;
                        state       <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                EXEC: begin
                    instr_valid <= 1'b0;
                    if (halt) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        pc       <= next_pc;
                        imem_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                HALT, FAULT: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
